fifo_rr_scheduler: RTL and testbench
====================================

Name: fifo_rr_scheduler

Overview:
- Round-robin read scheduler that drains NUM_FIFOS source FIFOs (fifo-style: read/buffer_out/fifo_empty/error) into one shared downstream FIFO.
- Issues one-hot pops, forwards the popped word as a push, and throttles on the downstream almost_full flag.
- Loads almost-full/almost-empty thresholds (umb_*) into all FIFOs after reset or on request.
- Latches FIFO errors and halts the datapath until reset.

Parameters:
- NUM_FIFOS, 4, number of source FIFOs.
- DATA_SIZE, 4, word width; matches FIFO buff_in/buffer_out.
- UMB_AF_RST, 6, umb_almost_full value while in reset.
- UMB_AE_RST, 2, umb_almost_empty value while in reset.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  request threshold reload; honoured only in IDLE.
- umb_af_in  in  DATA_SIZE  almost-full threshold to load.
- umb_ae_in  in  DATA_SIZE  almost-empty threshold to load.
- fifo_empty  in  NUM_FIFOS  source fifo_empty flags, bit i = FIFO i.
- fifo_error  in  NUM_FIFOS  source error flags.
- fifo_data  in  NUM_FIFOS*DATA_SIZE  concatenated source buffer_out; FIFO i at [i*DATA_SIZE +: DATA_SIZE].
- out_almost_full  in  1  downstream almost_full.
- out_full  in  1  downstream fifo_full.
- pop  out  NUM_FIFOS  one-hot read strobes to source FIFOs.
- push  out  1  write strobe to downstream FIFO.
- data_out  out  DATA_SIZE  word written downstream.
- umb_almost_full  out  DATA_SIZE  threshold driven to all FIFOs.
- umb_almost_empty  out  DATA_SIZE  threshold driven to all FIFOs.
- state  out  3  current state encoding.
- idle_out  out  1  high in IDLE with all sources empty.
- error_out  out  1  sticky error.

Behaviour:
- All outputs are registered.
- Reset values (asynchronous):
  - state = RESET.
  - pop = 0, push = 0, data_out = 0.
  - umb_almost_full = UMB_AF_RST, umb_almost_empty = UMB_AE_RST.
  - idle_out = 0, error_out = 0.
  - Round-robin pointer = NUM_FIFOS-1, so FIFO 0 has first priority.
  - In-flight pipeline cleared.
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET -> INIT on the first edge after reset deasserts.
- INIT lasts one cycle. It latches umb_af_in/umb_ae_in into the umb_* outputs, then -> IDLE.
- IDLE:
  - init=1 -> INIT (takes priority).
  - else any fifo_empty[i]=0 and out_almost_full=0 -> ACTIVE; the first pop is issued on that same edge.
- ACTIVE, at each edge:
  - If out_almost_full=0, grant the first non-empty FIFO searching upward (with wrap) from pointer+1, and set pop to that one-hot. The pointer moves to the granted index.
  - The FIFO popped in the previous cycle is ineligible this cycle. This prevents underflow, because fifo_empty updates one cycle after read. A single non-empty source is therefore popped every other cycle.
  - out_almost_full=1 -> pop = 0. In-flight words still complete; the downstream almost_full threshold must leave room for 2 words.
  - init is ignored.
- Pop-to-push latency = 2 cycles:
  - pop high in cycle k.
  - Source buffer_out is valid in cycle k+1.
  - push=1 and data_out = that FIFO's slice are registered for cycle k+2.
  - Throughput: up to 1 word/cycle with 2 or more active sources.
- ACTIVE -> IDLE when all fifo_empty=1 and no pop is in flight (pipeline drained).
- Any state except RESET -> ERROR when:
  - any fifo_error bit = 1, or
  - push would be asserted while out_full = 1. That word is dropped: push stays 0.
- ERROR:
  - pop = 0, push = 0, error_out = 1.
  - umb_* hold their values.
  - Exit only via reset.
- Reset asserted mid-operation: immediate return to reset values; in-flight words are discarded.
- Arithmetic: pointer is mod NUM_FIFOS. Thresholds are passed through unchanged and not range-checked.

Test Plan:
- Reset release with umb_af_in=3, umb_ae_in=1 -> umb outputs 6/2 during reset; state=INIT for 1 cycle; then 3/1 and state=IDLE, idle_out=1.
- FIFO0 holds 0xA,0xB; FIFO2 holds 0xC -> pop sequence 0001, 0100, 0001 on consecutive cycles; push with data_out 0xA, 0xC, 0xB, each 2 cycles after its pop; then IDLE.
- Only FIFO3 holds 3 words -> pop=1000 every other cycle (3 pops over 5 cycles); 3 pushes; no underflow.
- All 4 FIFOs non-empty, out_almost_full raised for 4 cycles mid-stream -> pops stop next edge; in-flight pushes (at most 2) complete; pops resume at the next rotation index.
- fifo_error[1] pulsed 1 cycle in ACTIVE -> state=ERROR, error_out=1, pop=push=0, held for 20 cycles until reset. Separately, push while out_full=1 -> ERROR with no push.
- reset asserted 1 cycle after a pop -> outputs return to reset values asynchronously; no push appears 2 cycles later.

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler: drains NUM_FIFOS source FIFOs into one shared
// downstream FIFO, loads almost-full/almost-empty thresholds into all FIFOs,
// and latches FIFO errors until reset.
//
// state  | meaning
// RESET  | held in reset, thresholds at reset defaults
// INIT   | one cycle, load umb_* thresholds from the inputs
// IDLE   | waiting for a non-empty source (or an init request)
// ACTIVE | issuing round-robin pops and forwarding popped words
// ERROR  | sticky fault, datapath halted until reset
module fifo_rr_scheduler #(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_SIZE  = 4,
  parameter int UMB_AF_RST = 6,
  parameter int UMB_AE_RST = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic [DATA_SIZE-1:0]           umb_af_in,
  input  logic [DATA_SIZE-1:0]           umb_ae_in,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS-1:0]           fifo_error,
  input  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data,
  input  logic                           out_almost_full,
  input  logic                           out_full,
  output logic [NUM_FIFOS-1:0]           pop,
  output logic                           push,
  output logic [DATA_SIZE-1:0]           data_out,
  output logic [DATA_SIZE-1:0]           umb_almost_full,
  output logic [DATA_SIZE-1:0]           umb_almost_empty,
  output logic [2:0]                     state,
  output logic                           idle_out,
  output logic                           error_out
);

  localparam int IDX_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     pop_idx;
  logic                 s1_valid;
  logic [IDX_W-1:0]     s1_idx;

  logic [NUM_FIFOS-1:0] eligible;
  logic                 gnt_found;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_FIFOS-1:0] gnt_onehot;
  logic                 err_hit;
  logic [DATA_SIZE-1:0] s1_word;

  // First eligible index searching upward from last+1 with wrap; last itself is tried last.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_FIFOS-1:0] elig,
                                             input logic [IDX_W-1:0]     last);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand = (int'(last) + k) % NUM_FIFOS;
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  // The FIFO being read this cycle still shows non-empty until after the edge,
  // so it is masked out to avoid popping it twice in a row (underflow).
  assign eligible   = ~fifo_empty & ~pop;
  assign {gnt_found, gnt_idx} = rr_pick(eligible, rr_ptr);
  assign gnt_onehot = {{(NUM_FIFOS-1){1'b0}}, 1'b1} << gnt_idx;

  // A word about to be pushed into a full downstream FIFO is a fault, as is any source error.
  assign err_hit    = (|fifo_error) || (s1_valid && out_full);
  assign s1_word    = fifo_data[s1_idx*DATA_SIZE +: DATA_SIZE];
  assign state      = state_q;

  // Sequencing FSM with registered outputs and the two-stage pop-to-push pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_RESET;
      pop              <= '0;
      pop_idx          <= '0;
      push             <= 1'b0;
      data_out         <= '0;
      umb_almost_full  <= DATA_SIZE'(UMB_AF_RST);
      umb_almost_empty <= DATA_SIZE'(UMB_AE_RST);
      idle_out         <= 1'b0;
      error_out        <= 1'b0;
      rr_ptr           <= IDX_W'(NUM_FIFOS - 1);
      s1_valid         <= 1'b0;
      s1_idx           <= '0;
    end else begin
      pop      <= '0;
      idle_out <= 1'b0;
      // Stage 1: source buffer_out is valid the cycle after the pop.
      s1_valid <= |pop;
      s1_idx   <= pop_idx;
      // Stage 2: forward the popped word downstream.
      push     <= s1_valid;
      if (s1_valid) data_out <= s1_word;

      case (state_q)
        S_RESET: state_q <= S_INIT;
        S_INIT: begin
          umb_almost_full  <= umb_af_in;
          umb_almost_empty <= umb_ae_in;
          idle_out         <= &fifo_empty;
          state_q          <= S_IDLE;
        end
        S_IDLE: begin
          if (init) begin
            state_q <= S_INIT;
          end else if (!(&fifo_empty) && !out_almost_full) begin
            state_q <= S_ACTIVE;
            pop     <= gnt_onehot;
            pop_idx <= gnt_idx;
            rr_ptr  <= gnt_idx;
          end else begin
            idle_out <= &fifo_empty;
          end
        end
        S_ACTIVE: begin
          if (!out_almost_full && gnt_found) begin
            pop     <= gnt_onehot;
            pop_idx <= gnt_idx;
            rr_ptr  <= gnt_idx;
          end else if ((&fifo_empty) && !(|pop) && !s1_valid) begin
            state_q  <= S_IDLE;
            idle_out <= 1'b1;
          end
        end
        S_ERROR: begin
          push     <= 1'b0;
          s1_valid <= 1'b0;
        end
        default: begin
          state_q   <= S_ERROR;
          push      <= 1'b0;
          s1_valid  <= 1'b0;
          error_out <= 1'b1;
        end
      endcase

      // Fault overrides everything above; the offending word is dropped.
      if (state_q != S_RESET && err_hit) begin
        state_q   <= S_ERROR;
        pop       <= '0;
        push      <= 1'b0;
        s1_valid  <= 1'b0;
        idle_out  <= 1'b0;
        error_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: behavioural source FIFOs, a round-robin grant
// model with a push scoreboard, directed scenarios and a randomized phase.
module tb_fifo_rr_scheduler;
  localparam int NF = 4;
  localparam int DW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             init;
  logic [DW-1:0]    umb_af_in, umb_ae_in;
  logic [NF-1:0]    fifo_empty;
  logic [NF-1:0]    fifo_error;
  logic [NF*DW-1:0] fifo_data;
  logic             out_almost_full, out_full;
  logic [NF-1:0]    pop;
  logic             push;
  logic [DW-1:0]    data_out, umb_almost_full, umb_almost_empty;
  logic [2:0]       state;
  logic             idle_out, error_out;

  fifo_rr_scheduler #(.NUM_FIFOS(NF), .DATA_SIZE(DW), .UMB_AF_RST(6), .UMB_AE_RST(2)) dut (
    .clk(clk), .reset(reset), .init(init), .umb_af_in(umb_af_in), .umb_ae_in(umb_ae_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_data(fifo_data),
    .out_almost_full(out_almost_full), .out_full(out_full), .pop(pop), .push(push),
    .data_out(data_out), .umb_almost_full(umb_almost_full), .umb_almost_empty(umb_almost_empty),
    .state(state), .idle_out(idle_out), .error_out(error_out));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 1'b1;
  int n_push = 0;
  int n_loaded = 0;

  logic [DW-1:0] srcq [NF][$];
  logic [NF-1:0] pop_log[$];
  logic [DW-1:0] push_log[$];

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int rr_next(input logic [NF-1:0] elig, input int last);
    for (int k = 1; k <= NF; k++)
      if (elig[(last + k) % NF]) return (last + k) % NF;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Source FIFO model: read on a sampled pop, buffer_out registered, empty flag one cycle late.
  logic [DW-1:0] rd_word;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NF; i++) srcq[i].delete();
      fifo_empty <= '1;
      fifo_data  <= '0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (pop[i]) begin
          check(srcq[i].size() > 0, "underflow", srcq[i].size(), 1);
          if (srcq[i].size() > 0) begin
            rd_word = srcq[i].pop_front();
            fifo_data[i*DW +: DW] <= rd_word;
          end
        end
      end
      for (int i = 0; i < NF; i++) fifo_empty[i] <= (srcq[i].size() == 0);
    end
  end

  // Monitor: expected grant from the round-robin rule, expected pushes via scoreboard.
  logic [NF-1:0] prev_empty, prev_exp_pop, exp_pop;
  logic          prev_af;
  bit            prev_valid = 1'b0;
  bit            due_now;
  int            last_gnt = NF - 1;
  int            g;
  exp_t          e;
  always @(negedge clk) begin
    if (reset) begin
      last_gnt     = NF - 1;
      prev_valid   = 1'b0;
      prev_exp_pop = '0;
      exp_q.delete();
    end else begin
      if (push) begin
        n_push++;
        push_log.push_back(data_out);
      end
      if (pop != '0) pop_log.push_back(pop);
      exp_pop = '0;
      if (chk_en && prev_valid) begin
        g = -1;
        if (!prev_af) g = rr_next(~prev_empty & ~prev_exp_pop, last_gnt);
        if (g >= 0) begin
          exp_pop[g] = 1'b1;
          last_gnt   = g;
          if (srcq[g].size() > 0) exp_q.push_back('{srcq[g][0], cyc + 2});
        end
        check(pop == exp_pop, "pop_grant", pop, exp_pop);
        due_now = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        if (push || due_now) begin
          check(push == due_now, "push_timing", push, due_now);
          if (push && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(data_out == e.data, "push_data", data_out, e.data);
          end else if (due_now) begin
            void'(exp_q.pop_front());
          end
        end
      end
      prev_empty   = fifo_empty;
      prev_exp_pop = exp_pop;
      prev_af      = out_almost_full;
      prev_valid   = 1'b1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int f, input logic [DW-1:0] w);
    srcq[f].push_back(w);
    n_loaded++;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while (k < max_cyc && !(exp_q.size() == 0 && idle_out && !push)) begin
      step();
      k++;
    end
    check(k < max_cyc, "idle_timeout", k, max_cyc);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base, k;
    bit  saw_push;
    reset = 1'b1; init = 1'b0; umb_af_in = 4'd3; umb_ae_in = 4'd1;
    fifo_error = '0; out_almost_full = 1'b0; out_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(state == 3'd0, "rst_state", state, 0);
    check(umb_almost_full == 4'd6, "rst_umb_af", umb_almost_full, 6);
    check(umb_almost_empty == 4'd2, "rst_umb_ae", umb_almost_empty, 2);
    check(pop == '0 && push == 1'b0, "rst_pop_push", {pop, push}, 0);
    check(data_out == '0, "rst_data", data_out, 0);
    check(idle_out == 1'b0 && error_out == 1'b0, "rst_flags", {idle_out, error_out}, 0);
    reset = 1'b0;
    step();
    check(state == 3'd1, "init_state", state, 1);
    check(umb_almost_full == 4'd6, "init_umb_hold", umb_almost_full, 6);
    step();
    check(state == 3'd2, "idle_state", state, 2);
    check(umb_almost_full == 4'd3 && umb_almost_empty == 4'd1, "umb_loaded",
          {umb_almost_full, umb_almost_empty}, 8'h31);
    check(idle_out == 1'b1, "idle_out", idle_out, 1);

    // init request from IDLE reloads thresholds
    umb_af_in = 4'd9; umb_ae_in = 4'd5; init = 1'b1;
    step();
    init = 1'b0;
    check(state == 3'd1, "reinit_state", state, 1);
    step();
    check(state == 3'd2 && umb_almost_full == 4'd9 && umb_almost_empty == 4'd5, "reinit_umb",
          {state, umb_almost_full, umb_almost_empty}, {3'd2, 4'd9, 4'd5});

    // two sources, fixed pattern
    pop_log.delete(); push_log.delete();
    load(0, 4'hA); load(0, 4'hB); load(2, 4'hC);
    step(3);
    wait_idle(40);
    check(pop_log.size() == 3, "t2_pop_count", pop_log.size(), 3);
    if (pop_log.size() == 3)
      check({pop_log[0], pop_log[1], pop_log[2]} == 12'b0001_0100_0001, "t2_pop_seq",
            {pop_log[0], pop_log[1], pop_log[2]}, 12'b0001_0100_0001);
    check(push_log.size() == 3, "t2_push_count", push_log.size(), 3);
    if (push_log.size() == 3)
      check({push_log[0], push_log[1], push_log[2]} == 12'hACB, "t2_push_seq",
            {push_log[0], push_log[1], push_log[2]}, 12'hACB);

    // single source: popped every other cycle
    base = n_push; pop_log.delete();
    for (int i = 0; i < 3; i++) load(3, DW'($urandom_range(0, 15)));
    step(3);
    wait_idle(40);
    check(n_push - base == 3, "t3_push_count", n_push - base, 3);
    check(pop_log.size() == 3, "t3_pop_count", pop_log.size(), 3);

    // all sources busy, downstream almost_full for 4 cycles
    base = n_push;
    for (int w = 0; w < 5; w++)
      for (int f = 0; f < NF; f++) load(f, DW'($urandom_range(0, 15)));
    step(5);
    out_almost_full = 1'b1;
    step(4);
    out_almost_full = 1'b0;
    wait_idle(100);
    check(n_push - base == 20, "t4_push_count", n_push - base, 20);

    // randomized traffic
    base = n_push; n_loaded = 0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, NF - 1)), DW'($urandom_range(0, 15)));
      out_almost_full = ($urandom_range(0, 4) == 0);
      step();
    end
    out_almost_full = 1'b0;
    step(2);
    wait_idle(400);
    check(n_push - base == n_loaded, "rand_push_count", n_push - base, n_loaded);

    // source error pulse in ACTIVE
    chk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin load(1, 4'h1); load(2, 4'h2); end
    step(4);
    fifo_error = 4'b0010;
    step();
    fifo_error = '0;
    check(state == 3'd4 && error_out == 1'b1, "err_enter", {state, error_out}, {3'd4, 1'b1});
    check(pop == '0 && push == 1'b0, "err_outputs", {pop, push}, 0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (state == 3'd4 && error_out && pop == '0 && !push) k++;
    end
    check(k == 20, "err_hold", k, 20);
    check(umb_almost_full == 4'd9 && umb_almost_empty == 4'd5, "err_umb_hold",
          {umb_almost_full, umb_almost_empty}, 8'h95);
    pulse_reset();

    // push into a full downstream FIFO
    out_full = 1'b1;
    load(0, 4'h5);
    saw_push = 1'b0; k = 0;
    while (k < 10 && state != 3'd4) begin
      step();
      saw_push |= push;
      k++;
    end
    check(state == 3'd4 && error_out == 1'b1, "full_err", {state, error_out}, {3'd4, 1'b1});
    check(saw_push == 1'b0, "full_no_push", saw_push, 0);
    out_full = 1'b0;
    reset = 1'b1;
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    step(2);

    // reset one cycle after a pop
    load(1, 4'h7);
    k = 0;
    while (k < 10 && pop == '0) begin
      step();
      k++;
    end
    check(pop == 4'b0010, "rst_mid_pop", pop, 2);
    step();
    reset = 1'b1;
    #1;
    check(state == 3'd0 && pop == '0 && push == 1'b0, "rst_mid_async", {state, pop, push}, 0);
    check(umb_almost_full == 4'd6 && umb_almost_empty == 4'd2, "rst_mid_umb",
          {umb_almost_full, umb_almost_empty}, 8'h62);
    saw_push = 1'b0;
    step();
    saw_push |= push;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      saw_push |= push;
    end
    check(saw_push == 1'b0, "rst_mid_no_push", saw_push, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
